// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the front-panel debouncer bank.
//   - ACTIVE_LOW_DEFAULT : default button polarity (1 = pressed pulls the pin low)
//   - idle_level()       : resting pin level for a given polarity
//   - press_level()      : pin level while the button is held
//   - fits_width()       : true when a count value fits in an unsigned field
//   - max2()             : larger of two counts (sizes the hold counter)
//   No ports; imported by debounce_chan and debounce_bank.
// -----------------------------------------------------------------------------
package debounce_pkg;

  localparam int ACTIVE_LOW_DEFAULT = 1;

  // Resting level: a pull-up button idles high when it is active-low.
  function automatic logic idle_level(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic press_level(input int active_low);
    return (active_low != 0) ? 1'b0 : 1'b1;
  endfunction

  // value < 2**width, written with $clog2 so it stays valid for wide fields.
  function automatic bit fits_width(input longint unsigned value, input int width);
    return $clog2(value + 64'd1) <= width;
  endfunction

  function automatic longint unsigned max2(input longint unsigned a,
                                           input longint unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
//   One debounced input: 2-flop synchroniser, qualification counter, accepted
//   level, one-cycle press/release pulses, optional long-press / auto-repeat.
//   Build option: define DEBOUNCE_LONGPRESS_EN to include the hold counter and
//   o_long generation; otherwise o_long is tied low and no hold logic exists.
//
//   Ports
//     i_clk      in   system clock
//     i_reset    in   asynchronous, active-low reset
//     i_switch   in   raw asynchronous pin
//     o_level    out  accepted level, raw pin polarity
//     o_pressed  out  accepted level is the pressed level
//     o_press    out  1-cycle pulse when idle->pressed is accepted
//     o_release  out  1-cycle pulse when pressed->idle is accepted
//     o_long     out  1-cycle long-press / repeat pulse (0 when compiled out)
// -----------------------------------------------------------------------------
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int ACTIVE_LOW      = ACTIVE_LOW_DEFAULT,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int HOLD_W          = 32
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_switch,
  output logic o_level,
  output logic o_pressed,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam logic IDLE_LVL  = idle_level(ACTIVE_LOW);
  localparam logic PRESS_LVL = press_level(ACTIVE_LOW);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Elaboration-time sanity checks on the configuration.
  if (DEBOUNCE_CYCLES < 1) begin : g_err_cycles
    $error("debounce_chan: DEBOUNCE_CYCLES must be at least 1");
  end
  if (!fits_width(longint'(DEBOUNCE_CYCLES), CNT_W)) begin : g_err_cnt_w
    $error("debounce_chan: DEBOUNCE_CYCLES does not fit in CNT_W bits");
  end
  if (LONG_CYCLES < 1) begin : g_err_long
    $error("debounce_chan: LONG_CYCLES must be at least 1");
  end
  if (!fits_width(max2(longint'(LONG_CYCLES), longint'(REPEAT_CYCLES)), HOLD_W))
  begin : g_err_hold_w
    $error("debounce_chan: HOLD_W too narrow for LONG_CYCLES/REPEAT_CYCLES");
  end

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic [CNT_W-1:0] r_cnt;

  logic w_differs;
  logic w_window_full;
  logic w_accept;

  assign w_differs     = (r_sync2 != r_level);
  assign w_window_full = (r_cnt == CNT_LAST);
  // A new level is taken only after DEBOUNCE_CYCLES consecutive differing
  // samples; any agreeing sample in between clears the count.
  assign w_accept      = w_differs && w_window_full;

  // Sync flops reset to the idle level so reset release never looks like an
  // edge on the pin.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1   <= IDLE_LVL;
      r_sync2   <= IDLE_LVL;
      r_level   <= IDLE_LVL;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_switch;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_window_full) begin
        r_level   <= r_sync2;
        r_cnt     <= '0;
        r_press   <= (r_sync2 == PRESS_LVL);
        r_release <= (r_sync2 == IDLE_LVL);
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign o_level   = r_level;
  assign o_pressed = (r_level == PRESS_LVL);
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST =
    HOLD_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
  localparam logic              REPEAT_ON   = (REPEAT_CYCLES > 0);

  logic [HOLD_W-1:0] r_hcnt;
  logic              r_rpt;
  logic              w_held;
  logic              w_long_hit;
  logic              w_repeat_hit;

  // r_hcnt counts held cycles with the press-pulse cycle as cycle 0; the
  // pulse is decoded from it so it lands on the held cycle it names.
  assign w_held       = (r_level == PRESS_LVL);
  assign w_long_hit   = !r_rpt && (r_hcnt == LONG_LAST);
  assign w_repeat_hit = r_rpt && REPEAT_ON && (r_hcnt == REPEAT_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_hcnt <= '0;
      r_rpt  <= 1'b0;
    end else if (!w_held || w_accept) begin
      // Idle, or the release is being accepted on this edge.
      r_hcnt <= '0;
      r_rpt  <= 1'b0;
    end else if (w_long_hit) begin
      r_hcnt <= '0;
      r_rpt  <= 1'b1;
    end else if (w_repeat_hit) begin
      r_hcnt <= '0;
    end else if (!r_rpt || REPEAT_ON) begin
      // With repeat disabled the counter parks after the single long pulse.
      r_hcnt <= r_hcnt + HOLD_ONE;
    end
  end

  assign o_long = w_held && (w_long_hit || w_repeat_hit);
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//   N_CH independent push-button/switch debouncers for the front panel.
//   Each bit of the vectors belongs to one debounce_chan instance; this level
//   only fans the vectors out and back in.
//   Build option: DEBOUNCE_LONGPRESS_EN adds long-press / auto-repeat pulses on
//   o_long; without it o_long is constant 0.
//
//   Ports
//     i_clk      in   1     system clock
//     i_reset    in   1     asynchronous, active-low reset
//     i_switch   in   N_CH  raw asynchronous switch/button pins
//     o_level    out  N_CH  debounced level (raw polarity)
//     o_pressed  out  N_CH  debounced pressed state
//     o_press    out  N_CH  1-cycle pulse on idle->pressed acceptance
//     o_release  out  N_CH  1-cycle pulse on pressed->idle acceptance
//     o_long     out  N_CH  1-cycle long-press / auto-repeat pulse
// -----------------------------------------------------------------------------
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int ACTIVE_LOW      = ACTIVE_LOW_DEFAULT,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int HOLD_W          = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [N_CH-1:0] i_switch,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_pressed,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long
);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    debounce_chan #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .HOLD_W          (HOLD_W)
    ) u_chan (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_switch  (i_switch[g]),
      .o_level   (o_level[g]),
      .o_pressed (o_pressed[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_long    (o_long[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 16;
  localparam int DC     = 4;
  localparam int LONG   = 10;
  localparam int REP    = 5;
  localparam int HOLD_W = 32;
  localparam logic [N_CH-1:0] IDLE_V = {N_CH{1'b1}};

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] sw;
  logic [N_CH-1:0] o_level, o_pressed, o_press, o_release, o_long;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH            (N_CH),
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DC),
    .ACTIVE_LOW      (1),
    .LONG_CYCLES     (LONG),
    .REPEAT_CYCLES   (REP),
    .HOLD_W          (HOLD_W)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_switch  (sw),
    .o_level   (o_level),
    .o_pressed (o_pressed),
    .o_press   (o_press),
    .o_release (o_release),
    .o_long    (o_long)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check_vec(input string name, input logic [N_CH-1:0] act,
                           input logic [N_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A level is accepted once the last DC synchronised samples (all taken after
  // the previous acceptance) disagree with it. Pins reach the decision logic
  // two clocks after they are sampled.
  logic [N_CH-1:0] pin_q[$];
  logic [N_CH-1:0] hist_q[$];
  logic [N_CH-1:0] exp_level, exp_press, exp_release, exp_long;
  logic [N_CH-1:0] m_s;
  int              m_cyc;
  int              last_change[N_CH];
  int              held[N_CH];
  bit              m_flip;

`ifdef DEBOUNCE_LONGPRESS_EN
  function automatic bit long_due(input int h);
    if (h == LONG - 1) return 1'b1;
    if (REP > 0 && h > LONG - 1 && ((h - (LONG - 1)) % REP) == 0) return 1'b1;
    return 1'b0;
  endfunction
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_q.delete();
      pin_q.push_back(IDLE_V);
      pin_q.push_back(IDLE_V);
      hist_q.delete();
      exp_level   = IDLE_V;
      exp_press   = '0;
      exp_release = '0;
      exp_long    = '0;
      m_cyc       = 0;
      for (int c = 0; c < N_CH; c++) begin
        last_change[c] = 0;
        held[c]        = 0;
      end
    end else begin
      m_cyc++;
      pin_q.push_back(sw);
      m_s = pin_q.pop_front();
      hist_q.push_back(m_s);
      if (hist_q.size() > DC) void'(hist_q.pop_front());
      exp_press   = '0;
      exp_release = '0;
      exp_long    = '0;
      for (int c = 0; c < N_CH; c++) begin
        m_flip = (m_cyc - last_change[c] >= DC);
        if (m_flip) begin
          for (int k = 0; k < DC; k++)
            if (hist_q[hist_q.size() - 1 - k][c] == exp_level[c]) m_flip = 1'b0;
        end
        if (m_flip) begin
          exp_level[c]   = ~exp_level[c];
          last_change[c] = m_cyc;
          if (exp_level[c] == 1'b0) exp_press[c] = 1'b1;
          else                      exp_release[c] = 1'b1;
        end
        if (exp_level[c] == 1'b0) held[c] = exp_press[c] ? 0 : held[c] + 1;
        else                      held[c] = 0;
`ifdef DEBOUNCE_LONGPRESS_EN
        exp_long[c] = (exp_level[c] == 1'b0) && long_due(held[c]);
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check_vec("level",   o_level,   exp_level);
      check_vec("pressed", o_pressed, ~exp_level);
      check_vec("press",   o_press,   exp_press);
      check_vec("release", o_release, exp_release);
      check_vec("long",    o_long,    exp_long);
    end
  end

  // ---------------- driver helpers ----------------
  // Counts negedges until the chosen pulse shows; -1 if the bound expires.
  task automatic wait_pulse(input int ch, input bit rel, input int max_cyc,
                            output int n);
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < max_cyc) begin
      @(negedge clk);
      n++;
      hit = rel ? o_release[ch] : o_press[ch];
    end
    if (!hit) n = -1;
  endtask

  task automatic quiet_window(input string name, input int cyc);
    logic [N_CH-1:0] acc;
    acc = '0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      acc |= o_press | o_release | o_long;
    end
    check_vec(name, acc, '0);
  endtask

  // ---------------- stimulus ----------------
  int n;
  int got_q[$];
  int exp_long_q[$];
  int run_left[N_CH];

  initial begin
    sw    = IDLE_V;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset state and silence afterwards.
    @(negedge clk);
    check_vec("rst_level",   o_level,   4'hF);
    check_vec("rst_pressed", o_pressed, 4'h0);
    quiet_window("rst_quiet", 50);

    // 3-cycle glitch on ch0 must be rejected.
    sw[0] = 1'b0;
    repeat (3) @(negedge clk);
    sw[0] = 1'b1;
    quiet_window("glitch_quiet", 12);
    check_vec("glitch_level", o_level, 4'hF);

    // Steady press on ch0: accepted 6 clocks after the pin edge.
    sw[0] = 1'b0;
    wait_pulse(0, 1'b0, 20, n);
    check_int("press0_latency", n, 6);
    check_vec("press0_level", o_level, 4'hE);

    // Hold ch0 through held cycles 1..29 and log the long pulses.
    got_q.delete();
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      if (o_long[0]) got_q.push_back(k);
    end
`ifdef DEBOUNCE_LONGPRESS_EN
    for (int k = 9; k < 30; k += 5) exp_long_q.push_back(k);
`endif
    check_int("long_count", got_q.size(), exp_long_q.size());
    for (int i = 0; i < got_q.size() && i < exp_long_q.size(); i++)
      check_int("long_position", got_q[i], exp_long_q[i]);

    sw[0] = 1'b1;
    wait_pulse(0, 1'b1, 20, n);
    check_int("release0_latency", n, 6);
    check_vec("release0_level", o_level, 4'hF);
    quiet_window("after_release0", 15);

    // Bouncing ch1, then steady low.
    sw[1] = 1'b0; @(negedge clk);
    sw[1] = 1'b1; @(negedge clk);
    sw[1] = 1'b0; @(negedge clk);
    sw[1] = 1'b1; @(negedge clk);
    sw[1] = 1'b0;
    wait_pulse(1, 1'b0, 20, n);
    check_int("bounce_latency", n, 6);
    sw[1] = 1'b1;
    wait_pulse(1, 1'b1, 20, n);
    check_int("release1_latency", n, 6);
    repeat (5) @(negedge clk);

    // Simultaneous press and release on ch2/ch3.
    sw[3:2] = 2'b00;
    repeat (6) @(negedge clk);
    check_vec("pair_press", o_press, 4'b1100);
    sw[3:2] = 2'b11;
    repeat (6) @(negedge clk);
    check_vec("pair_release", o_release, 4'b1100);
    repeat (5) @(negedge clk);

    // Reset while ch0 is mid-hold and ch1 is mid-window (cnt=2).
    sw[0] = 1'b0;
    wait_pulse(0, 1'b0, 20, n);
    check_int("press0b_latency", n, 6);
    repeat (8) @(negedge clk);
    sw[1] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_vec("midrst_level",   o_level,   4'hF);
    check_vec("midrst_pressed", o_pressed, 4'h0);
    check_vec("midrst_press",   o_press,   4'h0);
    check_vec("midrst_release", o_release, 4'h0);
    check_vec("midrst_long",    o_long,    4'h0);
    sw = IDLE_V;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet_window("post_rst_quiet", 20);
    check_vec("post_rst_level", o_level, 4'hF);

    // Randomised runs on every channel, with one reset in the middle.
    for (int c = 0; c < N_CH; c++) run_left[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        sw = IDLE_V;
        for (int c = 0; c < N_CH; c++) run_left[c] = 0;
        rst_n = 1'b1;
      end
      for (int c = 0; c < N_CH; c++) begin
        if (run_left[c] == 0) begin
          sw[c] = 1'($urandom_range(0, 1));
          run_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 40))
                                                    : int'($urandom_range(1, 6));
        end
        run_left[c]--;
      end
    end
    sw = IDLE_V;
    repeat (60) @(negedge clk);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
